// File: rtl/wshb_arb_pkg.sv
// Shared types and constants for the two-requester Wishbone arbiter.
package wshb_arb_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        GNT0 = 2'b01,
        GNT1 = 2'b10
    } arb_state_t;

    typedef logic req_idx_t;

    localparam req_idx_t    REQ0            = 1'b0;
    localparam req_idx_t    REQ1            = 1'b1;
    localparam int unsigned TIMEOUT_DEFAULT = 1024;

endpackage

// File: rtl/wshb_if.sv
// Wishbone B4 bus bundle; master drives the request, slave drives the response.
interface wshb_if #(
    parameter int unsigned DATA_BYTES = 4
) ();

    logic                    cyc;
    logic                    stb;
    logic                    we;
    logic [31:0]             adr;
    logic [8*DATA_BYTES-1:0] dat_ms;
    logic [8*DATA_BYTES-1:0] dat_sm;
    logic [DATA_BYTES-1:0]   sel;
    logic [2:0]              cti;
    logic [1:0]              bte;
    logic                    ack;
    logic                    err;
    logic                    rty;

    modport master (
        output cyc, stb, we, adr, dat_ms, sel, cti, bte,
        input  dat_sm, ack, err, rty
    );

    modport slave (
        input  cyc, stb, we, adr, dat_ms, sel, cti, bte,
        output dat_sm, ack, err, rty
    );

endinterface

// File: rtl/wshb_timeout.sv
// Stalled-strobe watchdog: flags expiry after TIMEOUT consecutive stalled cycles.
module wshb_timeout
    import wshb_arb_pkg::*;
#(
    parameter int unsigned TIMEOUT = TIMEOUT_DEFAULT
) (
    input  logic sys_clk,
    input  logic sys_rst,
    input  logic stall,
    input  logic clear,
    output logic expired
);

    localparam int unsigned CW = $clog2(TIMEOUT + 1);

    logic [CW-1:0] count;

    assign expired = (count == CW'(TIMEOUT));

    // Expiry itself returns err to the owner, so it restarts the count.
    always_ff @(posedge sys_clk or negedge sys_rst) begin
        if (!sys_rst) begin
            count <= '0;
        end else if (clear || !stall || expired) begin
            count <= '0;
        end else begin
            count <= count + CW'(1);
        end
    end

endmodule

// File: rtl/wshb_arbiter2.sv
// Two-requester Wishbone arbiter, round-robin on ties, no pre-emption.
// Define WSHB_ARB_TIMEOUT_EN to build the stalled-strobe watchdog.
module wshb_arbiter2
    import wshb_arb_pkg::*;
#(
    parameter int unsigned TIMEOUT = TIMEOUT_DEFAULT
) (
    input  logic       sys_clk,
    input  logic       sys_rst,
    wshb_if.slave      wshb_ifs0,
    wshb_if.slave      wshb_ifs1,
    wshb_if.master     wshb_ifm,
    output logic [1:0] grant
);

    arb_state_t state;
    arb_state_t state_nxt;
    req_idx_t   last_grant;
    logic       own_stb;
    logic       expired;

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (wshb_ifs0.cyc && wshb_ifs1.cyc) begin
                    state_nxt = (last_grant == REQ1) ? GNT0 : GNT1;
                end else if (wshb_ifs0.cyc) begin
                    state_nxt = GNT0;
                end else if (wshb_ifs1.cyc) begin
                    state_nxt = GNT1;
                end
            end
            GNT0: if (!wshb_ifs0.cyc) state_nxt = wshb_ifs1.cyc ? GNT1 : IDLE;
            GNT1: if (!wshb_ifs1.cyc) state_nxt = wshb_ifs0.cyc ? GNT0 : IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge sys_clk or negedge sys_rst) begin
        if (!sys_rst) begin
            state      <= IDLE;
            last_grant <= REQ1;
            grant      <= '0;
        end else begin
            state <= state_nxt;
            case (state_nxt)
                GNT0: begin
                    grant      <= 2'b01;
                    last_grant <= REQ0;
                end
                GNT1: begin
                    grant      <= 2'b10;
                    last_grant <= REQ1;
                end
                default: grant <= '0;
            endcase
        end
    end

    always_comb begin
        wshb_ifm.cyc    = 1'b0;
        own_stb         = 1'b0;
        wshb_ifm.we     = 1'b0;
        wshb_ifm.adr    = '0;
        wshb_ifm.dat_ms = '0;
        wshb_ifm.sel    = '0;
        wshb_ifm.cti    = '0;
        wshb_ifm.bte    = '0;
        case (state)
            GNT0: begin
                wshb_ifm.cyc    = wshb_ifs0.cyc;
                own_stb         = wshb_ifs0.stb;
                wshb_ifm.we     = wshb_ifs0.we;
                wshb_ifm.adr    = wshb_ifs0.adr;
                wshb_ifm.dat_ms = wshb_ifs0.dat_ms;
                wshb_ifm.sel    = wshb_ifs0.sel;
                wshb_ifm.cti    = wshb_ifs0.cti;
                wshb_ifm.bte    = wshb_ifs0.bte;
            end
            GNT1: begin
                wshb_ifm.cyc    = wshb_ifs1.cyc;
                own_stb         = wshb_ifs1.stb;
                wshb_ifm.we     = wshb_ifs1.we;
                wshb_ifm.adr    = wshb_ifs1.adr;
                wshb_ifm.dat_ms = wshb_ifs1.dat_ms;
                wshb_ifm.sel    = wshb_ifs1.sel;
                wshb_ifm.cti    = wshb_ifs1.cti;
                wshb_ifm.bte    = wshb_ifs1.bte;
            end
            default: ;
        endcase
    end

    // A timed-out strobe is withdrawn from the slave in the cycle err is returned.
    assign wshb_ifm.stb = own_stb & ~expired;

    assign wshb_ifs0.ack    = (state == GNT0) & wshb_ifm.ack;
    assign wshb_ifs0.err    = (state == GNT0) & (wshb_ifm.err | expired);
    assign wshb_ifs0.rty    = (state == GNT0) & wshb_ifm.rty;
    assign wshb_ifs1.ack    = (state == GNT1) & wshb_ifm.ack;
    assign wshb_ifs1.err    = (state == GNT1) & (wshb_ifm.err | expired);
    assign wshb_ifs1.rty    = (state == GNT1) & wshb_ifm.rty;
    assign wshb_ifs0.dat_sm = wshb_ifm.dat_sm;
    assign wshb_ifs1.dat_sm = wshb_ifm.dat_sm;

`ifdef WSHB_ARB_TIMEOUT_EN
    wshb_timeout #(
        .TIMEOUT (TIMEOUT)
    ) u_timeout (
        .sys_clk (sys_clk),
        .sys_rst (sys_rst),
        .stall   (wshb_ifm.cyc & own_stb & ~(wshb_ifm.ack | wshb_ifm.err | wshb_ifm.rty)),
        .clear   (state_nxt != state),
        .expired (expired)
    );
`else
    assign expired = 1'b0;

    // TIMEOUT only has meaning with the watchdog built in.
    if (TIMEOUT == 0) begin : g_timeout_unused
    end
`endif

endmodule
